rv32_mc_control: RTL and testbench
==================================

# rv32_mc_control

Multicycle main control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes, mux selects and the 2-bit ALUOp consumed by the downstream ALU-control decoder. It also handles the memory ready handshake, traps unsupported opcodes, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  core clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12] from the instruction register
- zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- alu_op  out  2  00 ADD, 01 SUB, 10 use funct3/funct7
- alu_src_a  out  2  00 PC, 01 rs1, 10 old PC (PC of current instruction)
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write, mdr_write, pc_write, reg_write  out  1 each  register enables
- pc_src  out  1  0 ALU result, 1 ALUOut
- mem_to_reg  out  2  rd source: 00 ALUOut, 01 MDR, 10 PC
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky trap flag
- instret  out  32  retired-instruction counter

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JAL 10, TRAP 15. Unused encodings go to TRAP.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00. Hold until mem_ready=1. In that cycle ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00. This precomputes PC+imm into ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH, only if funct3 is 000 or 001; otherwise TRAP
  - 1101111 → JAL
  - any other opcode → TRAP
- EXEC_R: src_a=01, src_b=00, alu_op=10 → WB_ALU.
- EXEC_I: src_a=01, src_b=10. alu_op=00 when funct3=000 (ADDI must never see imm[11:5] as funct7), otherwise 10 → WB_ALU.
- ADDR: src_a=01, src_b=10, alu_op=00 → MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, iord=1. mdr_write=1 in the mem_ready cycle, then go to WB_MEM.
- MEM_WR: mem_write=1, iord=1. On mem_ready, go to FETCH.
- WB_ALU: reg_write=1, mem_to_reg=00 → FETCH.
- WB_MEM: reg_write=1, mem_to_reg=01 → FETCH.
- BRANCH: src_a=01, src_b=00, alu_op=01.
  - pc_write=1 with pc_src=1 when taken: (funct3=000 and zero) or (funct3=001 and !zero).
  - Always go to FETCH.
- JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=1 → FETCH.
- TRAP: illegal=1, all strobes 0, no exit except reset.
- Any output not listed for a state is 0.
- instret increments by 1 on each transition out of WB_ALU, WB_MEM, BRANCH, JAL, or out of MEM_WR with mem_ready. It wraps 0xFFFFFFFF → 0.

## Timing
- Reset (rst_n low, asynchronous):
  - state=FETCH, instret=0, illegal=0.
  - All strobes are forced to 0 while rst_n is low, including mem_read.
  - The first fetch request appears the cycle after rst_n rises.
- Minimum cycles per instruction, with zero-wait memory: R/I-ALU 4, load 5, store 4, branch 3, JAL 3.
- Each memory wait cycle adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- Handshake rules:
  - mem_read and mem_write are held stable until mem_ready is sampled high.
  - A mem_ready seen in a state with no memory strobe is ignored.
- Outputs are Moore-decoded from state, except the mem_ready-qualified enables (ir_write, pc_write in FETCH; mdr_write) and the zero-qualified pc_write in BRANCH.
- Reset asserted mid-instruction aborts it; no partial reg_write or pc_write occurs after the reset edge.

## Test plan
- Reset then R-type ADD (opcode 0110011), mem_ready=1 → states 0,1,2,7,0. reg_write exactly 1 cycle in state 7, alu_op=10 in state 2, instret=1.
- ADDI with funct3=000 and imm[11:5]=0100000 → alu_op=00 in EXEC_I. SRAI (funct3=101) → alu_op=10.
- Load with mem_ready low 3 cycles in both FETCH and MEM_RD → 11 cycles total. ir_write and mdr_write each pulse once, aligned to mem_ready. Then reg_write with mem_to_reg=01.
- BEQ with zero=1 → pc_write with pc_src=1. BNE with zero=1 → no pc_write. Both take 3 cycles, instret +2.
- Opcode 0000000, or branch funct3=100 → TRAP, illegal=1 and held with no strobes for 20 cycles. rst_n pulse clears it.
- Assert rst_n low during MEM_WR with mem_write=1 → mem_write drops immediately. After release: state=0, instret=0.
- Preload instret to 0xFFFFFFFF via a run of 2^32-1 forced retirements (or a force in the bench), then one retirement → instret=0.

Source files
------------

// File: rtl/rv32_mc_control.sv
// Multicycle main control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/writeback, drives datapath strobes and selects, traps bad opcodes, counts retirements.
module rv32_mc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic [1:0]  mem_to_reg,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_ADDI = 3'b000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t      state_q, state_d;
    logic        run_q;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        br_taken;

    // run_q holds every strobe low until the first edge after reset release,
    // and drops asynchronously with rst_n so no enable survives a mid-instruction reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign br_taken = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);

    always_comb begin
        state_d    = state_q;
        alu_op     = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        mem_to_reg = 2'b00;
        retire     = 1'b0;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // ALUOut <= old PC + imm, ready for branch/jump targets
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_R:              state_d = S_EXEC_R;
                        OP_IMM:            state_d = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_d = S_ADDR;
                        OP_BRANCH: state_d = ((funct3 == F3_BEQ) || (funct3 == F3_BNE))
                                             ? S_BRANCH : S_TRAP;
                        OP_JAL:            state_d = S_JAL;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b01;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_WB_ALU;
                end
                S_EXEC_I: begin
                    // ADDI must not let imm[11:5] masquerade as funct7
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_op    = (funct3 == F3_ADDI) ? ALU_ADD : ALU_FUNCT;
                    state_d   = S_WB_ALU;
                end
                S_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        mdr_write = 1'b1;
                        state_d   = S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b01;
                    alu_op    = ALU_SUB;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b10;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_TRAP: state_d = S_TRAP;
                default: state_d = S_TRAP;
            endcase
        end
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);
    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_rv32_mc_control.sv
// Directed bench for rv32_mc_control: walks each instruction class cycle by cycle
// and checks state, strobes, selects, trap and retirement counter against hand values.
module tb_rv32_mc_control;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  alu_op, alu_src_a, alu_src_b, mem_to_reg;
    logic        iord, mem_read, mem_write, ir_write, mdr_write, pc_write, reg_write, pc_src;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instret;

    int nvec = 0;
    int nerr = 0;
    int ncyc;

    rv32_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // strobe bundle {mem_read, mem_write, ir_write, mdr_write, pc_write, reg_write}
    task automatic chk_str(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, mem_read, mem_write, ir_write, mdr_write, pc_write, reg_write},
            {26'd0, exp});
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk_str("rst_strobes", 6'b000000);
        mem_ready = 1'b1; #1;
        chk_str("rst_ready_ignored", 6'b000000);
        rst_n = 1'b1; #1;
        chk_str("release_no_fetch_yet", 6'b000000);

        // R-type ADD: 0,1,2,7,0
        opcode = 7'b0110011; funct3 = 3'b000;
        cyc();
        chk("r_s0", {28'd0, state}, 32'd0);
        chk_str("r_fetch_strobes", 6'b101010);
        chk("r_fetch_srcb", {30'd0, alu_src_b}, 32'd1);
        cyc();
        chk("r_s1", {28'd0, state}, 32'd1);
        chk("r_dec_srca", {30'd0, alu_src_a}, 32'd2);
        chk("r_dec_srcb", {30'd0, alu_src_b}, 32'd2);
        chk_str("r_dec_strobes", 6'b000000);
        cyc();
        chk("r_s2", {28'd0, state}, 32'd2);
        chk("r_exec_aluop", {30'd0, alu_op}, 32'd2);
        chk("r_exec_srca", {30'd0, alu_src_a}, 32'd1);
        cyc();
        chk("r_s7", {28'd0, state}, 32'd7);
        chk_str("r_wb_strobes", 6'b000001);
        chk("r_wb_m2r", {30'd0, mem_to_reg}, 32'd0);
        cyc();
        chk("r_back_fetch", {28'd0, state}, 32'd0);
        chk("r_instret", instret, 32'd1);

        // ADDI with imm[11:5]=0100000 still adds
        opcode = 7'b0010011; funct3 = 3'b000;
        cyc();
        cyc();
        chk("addi_s3", {28'd0, state}, 32'd3);
        chk("addi_aluop", {30'd0, alu_op}, 32'd0);
        chk("addi_srcb", {30'd0, alu_src_b}, 32'd2);
        cyc();
        cyc();
        chk("addi_instret", instret, 32'd2);

        // SRAI uses funct decode
        funct3 = 3'b101;
        cyc();
        cyc();
        chk("srai_aluop", {30'd0, alu_op}, 32'd2);
        cyc();
        cyc();
        chk("srai_instret", instret, 32'd3);

        // Load, 3 wait cycles in FETCH and in MEM_RD: 11 cycles
        opcode = 7'b0000011; funct3 = 3'b010;
        mem_ready = 1'b0; #1;
        ncyc = 1;
        chk_str("ld_fwait1", 6'b100000);
        chk("ld_fetch_iord", {31'd0, iord}, 32'd0);
        repeat (2) begin
            cyc(); ncyc++;
            chk_str("ld_fwait", 6'b100000);
        end
        cyc(); ncyc++;
        mem_ready = 1'b1; #1;
        chk_str("ld_fready", 6'b101010);
        cyc(); ncyc++;
        mem_ready = 1'b0;
        chk("ld_s1", {28'd0, state}, 32'd1);
        cyc(); ncyc++;
        chk("ld_s4", {28'd0, state}, 32'd4);
        chk("ld_addr_aluop", {30'd0, alu_op}, 32'd0);
        chk("ld_addr_srcb", {30'd0, alu_src_b}, 32'd2);
        repeat (3) begin
            cyc(); ncyc++;
            chk("ld_s5", {28'd0, state}, 32'd5);
            chk_str("ld_mwait", 6'b100000);
        end
        chk("ld_mem_iord", {31'd0, iord}, 32'd1);
        cyc(); ncyc++;
        mem_ready = 1'b1; #1;
        chk_str("ld_mready", 6'b100100);
        cyc(); ncyc++;
        chk("ld_s8", {28'd0, state}, 32'd8);
        chk_str("ld_wb_strobes", 6'b000001);
        chk("ld_wb_m2r", {30'd0, mem_to_reg}, 32'd1);
        cyc();
        chk("ld_back_fetch", {28'd0, state}, 32'd0);
        chk("ld_cycles", ncyc, 32'd11);
        chk("ld_instret", instret, 32'd4);

        // BEQ taken
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        cyc();
        cyc();
        chk("beq_s9", {28'd0, state}, 32'd9);
        chk("beq_aluop", {30'd0, alu_op}, 32'd1);
        chk_str("beq_strobes", 6'b000010);
        chk("beq_pcsrc", {31'd0, pc_src}, 32'd1);
        cyc();
        chk("beq_back_fetch", {28'd0, state}, 32'd0);
        chk("beq_instret", instret, 32'd5);

        // BNE not taken with zero=1
        funct3 = 3'b001;
        cyc();
        cyc();
        chk("bne_s9", {28'd0, state}, 32'd9);
        chk_str("bne_strobes", 6'b000000);
        chk("bne_pcsrc", {31'd0, pc_src}, 32'd0);
        cyc();
        chk("bne_instret", instret, 32'd6);
        zero = 1'b0;

        // Store, zero-wait
        opcode = 7'b0100011; funct3 = 3'b010;
        cyc();
        cyc();
        chk("st_s4", {28'd0, state}, 32'd4);
        cyc();
        chk("st_s6", {28'd0, state}, 32'd6);
        chk_str("st_strobes", 6'b010000);
        chk("st_iord", {31'd0, iord}, 32'd1);
        cyc();
        chk("st_back_fetch", {28'd0, state}, 32'd0);
        chk("st_instret", instret, 32'd7);

        // JAL
        opcode = 7'b1101111;
        cyc();
        cyc();
        chk("jal_s10", {28'd0, state}, 32'd10);
        chk_str("jal_strobes", 6'b000011);
        chk("jal_m2r", {30'd0, mem_to_reg}, 32'd2);
        chk("jal_pcsrc", {31'd0, pc_src}, 32'd1);
        cyc();
        chk("jal_instret", instret, 32'd8);

        // instret wrap
        mem_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preload", instret, 32'hFFFF_FFFF);
        mem_ready = 1'b1;
        cyc();
        cyc();
        chk("wrap_s10", {28'd0, state}, 32'd10);
        cyc();
        chk("wrap_instret", instret, 32'd0);

        // Reset during MEM_WR aborts the store
        opcode = 7'b0100011;
        cyc();
        cyc();
        mem_ready = 1'b0;
        cyc();
        chk_str("abort_memwr", 6'b010000);
        rst_n = 1'b0; #1;
        chk_str("abort_strobes", 6'b000000);
        chk("abort_state", {28'd0, state}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("abort_rel_state", {28'd0, state}, 32'd0);
        chk("abort_rel_instret", instret, 32'd0);
        chk_str("abort_rel_fetch", 6'b100000);

        // Illegal opcode 0000000
        opcode = 7'b0000000; mem_ready = 1'b1;
        cyc();
        cyc();
        chk("trap0_s15", {28'd0, state}, 32'd15);
        chk("trap0_illegal", {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("trap0_hold_state", {28'd0, state}, 32'd15);
            chk("trap0_hold_illegal", {31'd0, illegal}, 32'd1);
            chk_str("trap0_hold_strobes", 6'b000000);
        end
        rst_n = 1'b0; #1;
        chk("trap0_clr_illegal", {31'd0, illegal}, 32'd0);
        chk("trap0_clr_state", {28'd0, state}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Branch with funct3=100 traps
        opcode = 7'b1100011; funct3 = 3'b100;
        cyc();
        cyc();
        chk("trapb_s15", {28'd0, state}, 32'd15);
        chk("trapb_illegal", {31'd0, illegal}, 32'd1);
        repeat (3) cyc();
        chk_str("trapb_strobes", 6'b000000);
        chk("trapb_instret", instret, 32'd0);
        rst_n = 1'b0; #1;
        chk("trapb_clr", {31'd0, illegal}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
